// File: rtl/cnn_conv1_acc_if.sv
// Handshake bundle between the conv1 multiplier stage, this accumulator and
// the downstream pixel consumer. The slave side is the accumulator.
interface cnn_conv1_acc_if #(
    parameter int PROD_WIDTH = 20,
    parameter int OUT_WIDTH  = 14
);
    logic signed [PROD_WIDTH-1:0] prod_din;
    logic                         prod_valid;
    logic                         prod_ready;
    logic signed [OUT_WIDTH-1:0]  bias_din;
    logic signed [OUT_WIDTH-1:0]  out_dout;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_sat;

    modport master (
        output prod_din, prod_valid, bias_din, out_ready,
        input  prod_ready, out_dout, out_valid, out_sat
    );

    modport slave (
        input  prod_din, prod_valid, bias_din, out_ready,
        output prod_ready, out_dout, out_valid, out_sat
    );
endinterface

// File: rtl/cnn_conv1_acc.sv
// conv1 pixel accumulator: sums TAPS signed products plus a pre-scaled bias,
// then floors by SHIFT, applies ReLU and clips to the positive output range.
module cnn_conv1_acc #(
    parameter int TAPS       = 25,
    parameter int PROD_WIDTH = 20,
    parameter int ACC_WIDTH  = 26,
    parameter int OUT_WIDTH  = 14,
    parameter int SHIFT      = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    cnn_conv1_acc_if.slave        bus
);
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                        state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]              tap_cnt;
    logic                          prod_rdy_q;
    logic signed [OUT_WIDTH-1:0]   dout_q;
    logic                          vld_q;
    logic                          sat_q;

    logic                          xfer;
    logic                          last;
    logic [CNT_W-1:0]              tap_nxt;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   sum_nxt;
    logic signed [ACC_WIDTH-1:0]   shr;
    logic signed [OUT_WIDTH-1:0]   res;
    logic                          res_sat;

    assign bus.prod_ready = prod_rdy_q;
    assign bus.out_dout   = dout_q;
    assign bus.out_valid  = vld_q;
    assign bus.out_sat    = sat_q;

    // next sum and activated result, evaluated for the tap being offered now
    always_comb begin
        xfer     = bus.prod_valid & prod_rdy_q;
        bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bus.bias_din[OUT_WIDTH-1]}}, bus.bias_din} <<< SHIFT;
        prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.prod_din[PROD_WIDTH-1]}}, bus.prod_din};
        // the first tap restarts from the bias, so any stale acc is irrelevant
        sum_nxt  = (state == IDLE) ? bias_ext + prod_ext : acc + prod_ext;
        tap_nxt  = (state == IDLE) ? CNT_W'(1) : tap_cnt + CNT_W'(1);
        last     = (tap_nxt == CNT_W'(TAPS));
        shr      = sum_nxt >>> SHIFT;
        res      = '0;
        res_sat  = 1'b0;
        if (shr[ACC_WIDTH-1]) begin
            res = '0;
        end else if (shr > OUT_MAX) begin
            res     = OUT_MAX[OUT_WIDTH-1:0];
            res_sat = 1'b1;
        end else begin
            res = shr[OUT_WIDTH-1:0];
        end
    end

    // control FSM with registered handshake and output data
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            tap_cnt    <= '0;
            prod_rdy_q <= 1'b1;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (xfer) begin
                        acc     <= sum_nxt;
                        tap_cnt <= tap_nxt;
                        if (last) begin
                            dout_q     <= res;
                            sat_q      <= res_sat;
                            vld_q      <= 1'b1;
                            prod_rdy_q <= 1'b0;
                            state      <= OUT;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                OUT: begin
                    // ready only rises the cycle after the pop, so no tap
                    // can be taken in the same cycle as an output leaves
                    if (bus.out_ready) begin
                        vld_q      <= 1'b0;
                        prod_rdy_q <= 1'b1;
                        tap_cnt    <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    prod_rdy_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/cnn_conv1_acc.md
CNN_CONV1_ACC -- requirements
Module: cnn_conv1_acc

Interface
REQ-001 SHALL provide parameter TAPS, default 25, products per output pixel (5x5 kernel).
REQ-002 SHALL provide parameter PROD_WIDTH, default 20, signed product width from the 14s x 6s multiplier.
REQ-003 SHALL provide parameter ACC_WIDTH, default 26, signed accumulator width.
REQ-004 SHALL provide parameter OUT_WIDTH, default 14, signed output width.
REQ-005 SHALL provide parameter SHIFT, default 5, fractional bits removed from the accumulator.
REQ-006 SHALL provide port ap_clk, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL provide port ap_rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-008 SHALL provide port prod_din, input, PROD_WIDTH, signed product from the multiplier.
REQ-009 SHALL provide port prod_valid, input, 1, prod_din valid.
REQ-010 SHALL provide port prod_ready, output, 1, block accepts a product this cycle.
REQ-011 SHALL provide port bias_din, input, OUT_WIDTH, signed bias; sampled with the first tap of each pixel.
REQ-012 SHALL provide port out_dout, output, OUT_WIDTH, signed activated pixel.
REQ-013 SHALL provide port out_valid, output, 1, out_dout valid.
REQ-014 SHALL provide port out_ready, input, 1, downstream accepts out_dout.
REQ-015 SHALL provide port out_sat, output, 1, out_dout was clipped at the positive limit; qualified by out_valid.

Function
REQ-016 SHALL count a product transfer only when prod_valid and prod_ready are both 1 on a rising edge.
REQ-017 SHALL implement states IDLE, ACC and OUT.
REQ-018 SHALL drive prod_ready=1 in IDLE and ACC, and prod_ready=0 in OUT.
REQ-019 SHALL, on a transfer in IDLE: load acc = sign-extended (bias_din << SHIFT) + prod_din, set tap_cnt=1, and go to ACC.
REQ-020 SHALL, on a transfer in ACC: add sign-extended prod_din to acc and increment tap_cnt.
REQ-021 SHALL, on the transfer that makes tap_cnt reach TAPS, compute the result from the updated sum and go to OUT.
  - Result: arithmetic shift right by SHIFT (floor).
  - Then ReLU: negative becomes 0.
  - Then saturate to 2^(OUT_WIDTH-1)-1 (8191 at defaults), setting out_sat when clipped.
REQ-022 SHALL, when TAPS=1, go directly from IDLE to OUT on one transfer.
REQ-023 SHALL register out_dout and out_sat and assert out_valid on the cycle after the last tap transfer, giving 1-cycle latency.
REQ-024 SHALL hold out_dout, out_sat and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, in OUT with out_ready=1: deassert out_valid next cycle, return to IDLE, and reset tap_cnt to 0.
REQ-026 SHALL NOT accept a new product in the same cycle an output is popped; the first tap of the next pixel is accepted no earlier than the following cycle.
REQ-027 SHALL size the accumulator so that TAPS x 2^18 + 2^(OUT_WIDTH-1+SHIFT) never overflows ACC_WIDTH; no wrap-around occurs at defaults.
REQ-028 SHALL treat prod_din as don't-care and leave acc unchanged when prod_valid=0.
REQ-029 SHALL ignore out_ready outside OUT.

Reset
REQ-030 SHALL, while ap_rst_n=0, force state=IDLE, acc=0, tap_cnt=0, out_dout=0, out_valid=0 and out_sat=0; prod_ready=1 after release.
REQ-031 SHALL discard any partial sum when reset asserts mid-pixel; the next transfer after release is treated as tap 0.

Verification
REQ-032 SHALL cover basic accumulation: 25 products of 32 with bias 0 -> out_dout=25, out_sat=0, out_valid one cycle after the 25th transfer.
REQ-033 SHALL cover ReLU: 25 products of -64 with bias 10 (sum -1280) -> out_dout=0, out_sat=0.
REQ-034 SHALL cover saturation: 25 products of 262144 with bias 8191 -> out_dout=8191, out_sat=1.
REQ-035 SHALL cover backpressure: out_ready held 0 for 3 cycles -> out_dout held stable, prod_ready=0 throughout; pop on cycle 4, then a new pixel is accepted next cycle.
REQ-036 SHALL cover reset mid-pixel: ap_rst_n pulsed low after 10 taps, then 25 products of 32 with bias 0 -> out_dout=25.
REQ-037 SHALL cover gapped input: prod_valid toggled randomly over 25 taps of 1 with bias 3 -> out_dout=3 (floor((96+25)/32)).
